// File: rtl/alu_isa_pkg.sv
// Shared ALU instruction-set definitions: opcodes, instruction field positions,
// issue FSM states and opcode classification helpers.
package alu_isa_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_W   = 3;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LS  = 4'b0011;
  localparam logic [3:0] OP_SRS = 4'b0100;
  localparam logic [3:0] OP_URS = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_RRO = 4'b1000;
  localparam logic [3:0] OP_LRO = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1111;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int RT_HI  = 5;
  localparam int RT_LO  = 3;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_ILL
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_LS) || (op == OP_SRS) || (op == OP_URS) ||
           (op == OP_RRO) || (op == OP_LRO);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_LRO) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational field extraction and classification of one ALU instruction.
module alu_instr_decode
  import alu_isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [4:0]         shamt,
  output logic               use_rt,
  output logic               legal
);

  logic shift_op;

  always_comb begin
    opcode   = instr[OPC_HI:OPC_LO];
    rd       = instr[RD_HI:RD_LO];
    rs       = instr[RS_HI:RS_LO];
    rt       = instr[RT_HI:RT_LO];
    shift_op = is_shift_op(opcode);
    // shamt overlaps rt; only one of the two is meaningful for a given opcode
    shamt    = shift_op ? instr[SH_HI:SH_LO] : 5'd0;
    use_rt   = !shift_op;
    legal    = is_legal_op(opcode);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accept one instruction, read operands, drive the
// ALU, capture its result/flags and write the result back to the register file.
module alu_issue_ctrl
  import alu_isa_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic                instr_ready,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [3:0]          flags,
  output logic [REG_W-1:0]    rf_raddr_a,
  output logic [REG_W-1:0]    rf_raddr_b,
  input  logic [DATA_W-1:0]   rf_rdata_a,
  input  logic [DATA_W-1:0]   rf_rdata_b,
  output logic                rf_we,
  output logic [REG_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [DATA_W-1:0]   alu_ina,
  output logic [DATA_W-1:0]   alu_inb,
  output logic [3:0]          alu_op,
  output logic [4:0]          alu_shamt,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_cr,
  input  logic                alu_ov,
  input  logic                alu_ng,
  input  logic                alu_zr
);

  logic [3:0]        dec_opcode;
  logic [REG_W-1:0]  dec_rd;
  logic [REG_W-1:0]  dec_rs;
  logic [REG_W-1:0]  dec_rt;
  logic [4:0]        dec_shamt;
  logic              dec_use_rt;
  logic              dec_legal;

  alu_instr_decode u_decode (
    .instr  (instr),
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .shamt  (dec_shamt),
    .use_rt (dec_use_rt),
    .legal  (dec_legal)
  );

  state_t            state_q,  state_d;
  logic [3:0]        op_q,     op_d;
  logic [REG_W-1:0]  rd_q,     rd_d;
  logic [REG_W-1:0]  rs_q,     rs_d;
  logic [REG_W-1:0]  rt_q,     rt_d;
  logic [4:0]        shamt_q,  shamt_d;
  logic              use_rt_q, use_rt_d;
  logic [DATA_W-1:0] opa_q,    opa_d;
  logic [DATA_W-1:0] opb_q,    opb_d;
  logic [DATA_W-1:0] res_q,    res_d;
  logic [3:0]        aflags_q, aflags_d;
  logic [3:0]        flags_q,  flags_d;
  logic              ready_q,  ready_d;
  logic              done_q,   done_d;
  logic              ill_q,    ill_d;
  logic              we_q,     we_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    shamt_d  = shamt_q;
    use_rt_d = use_rt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    aflags_d = aflags_q;
    flags_d  = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          op_d     = dec_opcode;
          rd_d     = dec_rd;
          rs_d     = dec_rs;
          rt_d     = dec_rt;
          shamt_d  = dec_shamt;
          use_rt_d = dec_use_rt;
          state_d  = dec_legal ? ST_READ : ST_ILL;
        end
      end
      ST_READ: begin
        opa_d   = rf_rdata_a;
        opb_d   = rf_rdata_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d    = alu_out;
        aflags_d = {alu_ng, alu_zr, alu_ov, alu_cr};
        state_d  = ST_WB;
      end
      ST_WB: begin
        flags_d = aflags_q;
        state_d = ST_IDLE;
      end
      ST_ILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered, so they are derived from the next state
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_WB) || (state_d == ST_ILL);
    ill_d   = (state_d == ST_ILL);
    we_d    = (state_d == ST_WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      shamt_q  <= '0;
      use_rt_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      aflags_q <= '0;
      flags_q  <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      shamt_q  <= shamt_d;
      use_rt_q <= use_rt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      aflags_q <= aflags_d;
      flags_q  <= flags_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      ill_q    <= ill_d;
      we_q     <= we_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign illegal     = ill_q;
  assign flags       = flags_q;
  assign rf_raddr_a  = rs_q;
  assign rf_raddr_b  = rt_q;
  assign rf_we       = we_q;
  assign rf_waddr    = rd_q;
  assign rf_wdata    = res_q;
  assign alu_ina     = opa_q;
  assign alu_inb     = use_rt_q ? opb_q : '0;
  assign alu_op      = op_q;
  assign alu_shamt   = shamt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: register-file and ALU models, a vector
// table run through a scoreboard, plus back-to-back and mid-operation reset sequences.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready, busy, done, illegal;
  logic [3:0]  flags;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [7:0]  rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [7:0]  alu_ina, alu_inb, alu_out;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_cr, alu_ov, alu_ng, alu_zr;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .flags       (flags),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_ina     (alu_ina),
    .alu_inb     (alu_inb),
    .alu_op      (alu_op),
    .alu_shamt   (alu_shamt),
    .alu_out     (alu_out),
    .alu_cr      (alu_cr),
    .alu_ov      (alu_ov),
    .alu_ng      (alu_ng),
    .alu_zr      (alu_zr)
  );

  // Static register file; write-backs are checked, not stored
  logic [7:0] rf [8];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  // Reference ALU
  logic [8:0]  alu_sum;
  logic [15:0] alu_rot;
  always_comb begin
    alu_out = 8'h00;
    alu_cr  = 1'b0;
    alu_ov  = 1'b0;
    alu_sum = 9'h000;
    alu_rot = 16'h0000;
    case (alu_op)
      4'h0: alu_out = alu_ina & alu_inb;
      4'h1: alu_out = alu_ina | alu_inb;
      4'h2: begin
        alu_sum = {1'b0, alu_ina} + {1'b0, alu_inb};
        alu_out = alu_sum[7:0];
        alu_cr  = alu_sum[8];
        alu_ov  = (alu_ina[7] == alu_inb[7]) && (alu_sum[7] != alu_ina[7]);
      end
      4'h3: alu_out = alu_ina << alu_shamt;
      4'h4: alu_out = $signed(alu_ina) >>> alu_shamt;
      4'h5: alu_out = alu_ina >> alu_shamt;
      4'h6: begin
        alu_sum = {1'b0, alu_ina} + {1'b0, ~alu_inb} + 9'd1;
        alu_out = alu_sum[7:0];
        alu_cr  = alu_sum[8];
        alu_ov  = (alu_ina[7] != alu_inb[7]) && (alu_sum[7] != alu_ina[7]);
      end
      4'h7: alu_out = ($signed(alu_ina) < $signed(alu_inb)) ? 8'h01 : 8'h00;
      4'h8: begin
        alu_rot = {alu_ina, alu_ina} >> alu_shamt[2:0];
        alu_out = alu_rot[7:0];
      end
      4'h9: begin
        alu_rot = {alu_ina, alu_ina} << alu_shamt[2:0];
        alu_out = alu_rot[15:8];
      end
      4'hF: alu_out = ~alu_ina;
      default: alu_out = 8'h00;
    endcase
  end
  assign alu_ng = alu_out[7];
  assign alu_zr = (alu_out == 8'h00);

  typedef struct {
    logic [15:0] ins;
    logic        ill;
    logic [7:0]  wdata;
    logic [3:0]  flg;
  } vec_t;

  typedef struct {
    logic       ill;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [3:0] flg;
  } sb_t;

  vec_t        vecs [16];
  sb_t         sbq [$];
  sb_t         cur;
  int unsigned acc_q [$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          flag_pend = 1'b0;
  logic [3:0]  flag_exp;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_s(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [4:0] sh);
    return {op, rd, rs, 1'b0, sh};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input vec_t v);
    sb_t e;
    e.ill   = v.ill;
    e.waddr = v.ins[11:9];
    e.wdata = v.wdata;
    e.flg   = v.flg;
    sbq.push_back(e);
  endtask

  // Called on a negedge; returns on the negedge where instr_ready is seen high
  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = instr_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: instr_ready stayed low for %0d cycles", n);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n && instr_valid && instr_ready) acc_q.push_back(cyc);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (flag_pend) begin
      chk("flags", {28'd0, flags}, {28'd0, flag_exp});
      flag_pend = 1'b0;
    end
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=%b with empty scoreboard", done);
      end else begin
        cur = sbq.pop_front();
        $display("txn ill=%b we=%b waddr=%0d wdata=%02h exp_wdata=%02h",
                 illegal, rf_we, rf_waddr, rf_wdata, cur.wdata);
        chk("illegal", {31'd0, illegal}, {31'd0, cur.ill});
        chk("rf_we", {31'd0, rf_we}, {31'd0, !cur.ill});
        if (!cur.ill) begin
          chk("rf_waddr", {29'd0, rf_waddr}, {29'd0, cur.waddr});
          chk("rf_wdata", {24'd0, rf_wdata}, {24'd0, cur.wdata});
        end
        flag_pend = 1'b1;
        flag_exp  = cur.flg;
      end
    end else if (rf_we) begin
      checks++;
      errors++;
      $display("FAIL stray_write: rf_we=%b without done", rf_we);
    end
  end

  task automatic issue(input vec_t v);
    bit         ok;
    logic [3:0] op;
    bit         sh;
    op = v.ins[15:12];
    sh = (op == 4'h3) || (op == 4'h4) || (op == 4'h5) || (op == 4'h8) || (op == 4'h9);
    instr_valid = 1'b1;
    instr       = v.ins;
    wait_ready(ok);
    if (!ok) begin
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_exp(v);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ready_n1", {31'd0, instr_ready}, 32'd0);
    chk("busy_n1", {31'd0, busy}, 32'd1);
    if (v.ill) begin
      chk("ill_done_n1", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("ill_ready_n2", {31'd0, instr_ready}, 32'd1);
      chk("ill_busy_n2", {31'd0, busy}, 32'd0);
    end else begin
      chk("done_n1", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("exec_op", {28'd0, alu_op}, {28'd0, op});
      chk("exec_ina", {24'd0, alu_ina}, {24'd0, rf[v.ins[8:6]]});
      chk("exec_inb", {24'd0, alu_inb}, sh ? 32'd0 : {24'd0, rf[v.ins[5:3]]});
      chk("exec_shamt", {27'd0, alu_shamt}, sh ? {27'd0, v.ins[4:0]} : 32'd0);
      chk("ready_n2", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      chk("wb_done_n3", {31'd0, done}, 32'd1);
      chk("wb_we_n3", {31'd0, rf_we}, 32'd1);
      chk("ready_n3", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      chk("ready_n4", {31'd0, instr_ready}, 32'd1);
      chk("busy_n4", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int unsigned a0, a1;

    rf[0] = 8'h00; rf[1] = 8'h7F; rf[2] = 8'h01; rf[3] = 8'h3C;
    rf[4] = 8'h81; rf[5] = 8'h55; rf[6] = 8'h55; rf[7] = 8'hF0;

    vecs[0]  = '{enc_r(4'h2, 3'd3, 3'd1, 3'd2), 1'b0, 8'h80, 4'b1010}; // ADD overflow
    vecs[1]  = '{enc_r(4'h6, 3'd0, 3'd5, 3'd6), 1'b0, 8'h00, 4'b0101}; // SUB equal
    vecs[2]  = '{enc_s(4'h3, 3'd7, 3'd4, 5'd3), 1'b0, 8'h08, 4'b0000}; // LS
    vecs[3]  = '{enc_r(4'h0, 3'd2, 3'd1, 3'd7), 1'b0, 8'h70, 4'b0000}; // AND
    vecs[4]  = '{enc_r(4'h1, 3'd2, 3'd4, 3'd7), 1'b0, 8'hF1, 4'b1000}; // OR
    vecs[5]  = '{enc_s(4'h4, 3'd1, 3'd7, 5'd2), 1'b0, 8'hFC, 4'b1000}; // SRS
    vecs[6]  = '{enc_s(4'h5, 3'd1, 3'd7, 5'd4), 1'b0, 8'h0F, 4'b0000}; // URS
    vecs[7]  = '{enc_r(4'h7, 3'd1, 3'd7, 3'd1), 1'b0, 8'h01, 4'b0000}; // SLT
    vecs[8]  = '{enc_s(4'h8, 3'd1, 3'd4, 5'd1), 1'b0, 8'hC0, 4'b1000}; // RRO
    vecs[9]  = '{enc_s(4'h9, 3'd1, 3'd4, 5'd2), 1'b0, 8'h06, 4'b0000}; // LRO
    vecs[10] = '{enc_r(4'hF, 3'd6, 3'd0, 3'd1), 1'b0, 8'hFF, 4'b1000}; // NOT
    vecs[11] = '{enc_r(4'h6, 3'd5, 3'd2, 3'd1), 1'b0, 8'h82, 4'b1000}; // SUB borrow
    vecs[12] = '{enc_r(4'hB, 3'd2, 3'd1, 3'd2), 1'b1, 8'h00, 4'b1000}; // illegal
    vecs[13] = '{enc_r(4'hA, 3'd3, 3'd1, 3'd2), 1'b1, 8'h00, 4'b1000}; // illegal
    vecs[14] = '{enc_r(4'hE, 3'd4, 3'd1, 3'd2), 1'b1, 8'h00, 4'b1000}; // illegal
    vecs[15] = '{enc_r(4'h2, 3'd4, 3'd4, 3'd7), 1'b0, 8'h71, 4'b0011}; // ADD rd==rs, carry

    instr_valid = 1'b0;
    instr       = 16'h0000;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_wdata", {24'd0, rf_wdata}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready_held", {31'd0, instr_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 16; i++) issue(vecs[i]);
    @(negedge clk);

    // Back-to-back: instr_valid stays high across two accepts
    acc_q.delete();
    instr_valid = 1'b1;
    instr       = vecs[0].ins;
    wait_ready(ok);
    @(posedge clk);
    push_exp(vecs[0]);
    @(negedge clk);
    instr = vecs[1].ins;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_ready_low", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
    end
    wait_ready(ok);
    @(posedge clk);
    push_exp(vecs[1]);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("b2b_accepts", acc_q.size(), 32'd2);
    if (acc_q.size() >= 2) begin
      a0 = acc_q[0];
      a1 = acc_q[1];
      chk("b2b_spacing", a1 - a0, 32'd4);
    end
    chk("flags_before_rst", {28'd0, flags}, 32'b0101);

    // Reset dropped during EXEC
    instr_valid = 1'b1;
    instr       = vecs[0].ins;
    wait_ready(ok);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {28'd0, flags}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, instr_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_we", {31'd0, rf_we}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready_rel", {31'd0, instr_ready}, 32'd1);
    chk("midrst_flags_rel", {28'd0, flags}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle_we", {31'd0, rf_we}, 32'd0);
    end
    chk("sb_empty", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
